// File: rtl/datapath_result_feedback.sv
// -----------------------------------------------------------------------------
// datapath_result_feedback
//
// Per-thread result feedback for the triadic ALU. Every ALU result is delayed
// until it reaches the commit stage, where it updates a per-thread R entry and,
// when its write address hits the S window, one entry of a small per-thread
// S register file. Results whose Ra_valid is low are annulled: they do not
// write, so the thread's R and S keep their previous values. The R and S of
// a thread are registered onto the outputs one cycle after commit. That is
// exactly the cycle in which the thread next issues to the ALU.
//
// Optional feature macro: DATAPATH_RESULT_FEEDBACK_FLAGS_EN
//   defined     : R_zero / R_negative are decoded from the R output register
//   not defined : both flags are tied to 0
//
// Ports:
//   clock          in   clock
//   reset_n        in   asynchronous active-low reset
//   Ra             in   ALU result
//   write_addr_Ra  in   write address of the ALU result
//   Ra_valid       in   result comes from a non-annulled, non-cancelled op
//   s_read_index   in   S entry wanted by the thread issuing next cycle
//   R              out  previous committed result of the issuing thread
//   S              out  selected S entry of the issuing thread
//   R_zero         out  R == 0
//   R_negative     out  MSB of R
//   alu_thread     out  thread whose R/S are currently on the outputs
// -----------------------------------------------------------------------------
module datapath_result_feedback #(
   parameter int WORD_WIDTH         = 36,
   parameter int WRITE_ADDR_WIDTH   = 12,
   parameter int THREAD_COUNT       = 8,
   parameter int THREAD_COUNT_WIDTH = 3,
   parameter int ALU_PIPE_DEPTH     = 4,
   parameter int S_COUNT            = 2,
   parameter int S_INDEX_WIDTH      = 1,
   parameter int S_BASE_ADDR        = 0,
   parameter     S_RAMSTYLE         = "MLAB"
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [WORD_WIDTH-1:0]         Ra,
   input  logic [WRITE_ADDR_WIDTH-1:0]   write_addr_Ra,
   input  logic                          Ra_valid,
   input  logic [S_INDEX_WIDTH-1:0]      s_read_index,
   output logic [WORD_WIDTH-1:0]         R,
   output logic [WORD_WIDTH-1:0]         S,
   output logic                          R_zero,
   output logic                          R_negative,
   output logic [THREAD_COUNT_WIDTH-1:0] alu_thread
);

   // Delay from issue to commit. Commit happens one cycle before the thread
   // issues again, so the output register is loaded with the committing
   // thread itself.
   localparam int DEPTH = THREAD_COUNT - ALU_PIPE_DEPTH - 1;

   localparam logic [WRITE_ADDR_WIDTH:0] S_BASE_EXT  = (WRITE_ADDR_WIDTH + 1)'(S_BASE_ADDR);
   localparam logic [WRITE_ADDR_WIDTH:0] S_COUNT_EXT = (WRITE_ADDR_WIDTH + 1)'(S_COUNT);

   generate
      if (THREAD_COUNT < ALU_PIPE_DEPTH + 2 || S_RAMSTYLE == "") begin : g_bad_param
         $error("datapath_result_feedback: THREAD_COUNT must be at least ALU_PIPE_DEPTH+2");
      end
   endgenerate

   // (base + offset) mod N for a base already below N.
   function automatic logic [THREAD_COUNT_WIDTH-1:0] thread_add(
      input logic [THREAD_COUNT_WIDTH-1:0] base,
      input int                            offset
   );
      int sum;
      sum = int'(base) + (offset % THREAD_COUNT);
      if (sum >= THREAD_COUNT) begin
         sum = sum - THREAD_COUNT;
      end
      return THREAD_COUNT_WIDTH'(sum);
   endfunction

   // ---------------------------------------------------------------- thread counter
   logic [THREAD_COUNT_WIDTH-1:0] cur;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur <= '0;
      end else if (int'(cur) == THREAD_COUNT - 1) begin
         cur <= '0;
      end else begin
         cur <= cur + 1'b1;
      end
   end

   logic [THREAD_COUNT_WIDTH-1:0] rd_thread;

   assign alu_thread = thread_add(cur, ALU_PIPE_DEPTH);
   // Thread that will be on the outputs next cycle.
   assign rd_thread  = thread_add(cur, ALU_PIPE_DEPTH + 1);

   // ---------------------------------------------------------------- delay pipeline
   logic                          pipe_valid  [DEPTH];
   logic [WORD_WIDTH-1:0]         pipe_data   [DEPTH];
   logic [WRITE_ADDR_WIDTH-1:0]   pipe_addr   [DEPTH];
   logic [THREAD_COUNT_WIDTH-1:0] pipe_thread [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_pipe
         logic                          stage_valid;
         logic [WORD_WIDTH-1:0]         stage_data;
         logic [WRITE_ADDR_WIDTH-1:0]   stage_addr;
         logic [THREAD_COUNT_WIDTH-1:0] stage_thread;

         if (gi == 0) begin : g_first
            assign stage_valid  = Ra_valid;
            assign stage_data   = Ra;
            assign stage_addr   = write_addr_Ra;
            assign stage_thread = cur;
         end else begin : g_next
            assign stage_valid  = pipe_valid[gi-1];
            assign stage_data   = pipe_data[gi-1];
            assign stage_addr   = pipe_addr[gi-1];
            assign stage_thread = pipe_thread[gi-1];
         end

         // Only the valid bit is reset: clearing it is what discards the
         // in-flight results.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               pipe_valid[gi] <= 1'b0;
            end else begin
               pipe_valid[gi] <= stage_valid;
            end
         end

         always_ff @(posedge clock) begin
            pipe_data[gi]   <= stage_data;
            pipe_addr[gi]   <= stage_addr;
            pipe_thread[gi] <= stage_thread;
         end
      end
   endgenerate

   // ---------------------------------------------------------------- commit stage
   logic                          head_valid;
   logic [WORD_WIDTH-1:0]         head_data;
   logic [THREAD_COUNT_WIDTH-1:0] head_thread;
   logic [WRITE_ADDR_WIDTH:0]     s_offset;
   logic                          commit_r;
   logic                          commit_s;
   logic [S_INDEX_WIDTH-1:0]      commit_s_index;

   assign head_valid  = pipe_valid[DEPTH-1];
   assign head_data   = pipe_data[DEPTH-1];
   assign head_thread = pipe_thread[DEPTH-1];

   // An address below the base wraps to a huge offset, so one unsigned
   // compare covers both ends of the S window.
   assign s_offset       = {1'b0, pipe_addr[DEPTH-1]} - S_BASE_EXT;
   assign commit_r       = head_valid;
   assign commit_s       = head_valid && (s_offset < S_COUNT_EXT);
   assign commit_s_index = s_offset[S_INDEX_WIDTH-1:0];

   (* ramstyle = S_RAMSTYLE *) logic [WORD_WIDTH-1:0] r_file [THREAD_COUNT];
   (* ramstyle = S_RAMSTYLE *) logic [WORD_WIDTH-1:0] s_file [THREAD_COUNT][S_COUNT];

   always_ff @(posedge clock) begin
      if (commit_r) begin
         r_file[head_thread] <= head_data;
      end
      if (commit_s) begin
         s_file[head_thread][commit_s_index] <= head_data;
      end
   end

   // RAM contents are never cleared; these flags make unwritten entries read 0.
   logic [THREAD_COUNT-1:0]              r_written;
   logic [THREAD_COUNT-1:0][S_COUNT-1:0] s_written;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_written <= '0;
         s_written <= '0;
      end else begin
         if (commit_r) begin
            r_written[head_thread] <= 1'b1;
         end
         if (commit_s) begin
            s_written[head_thread][commit_s_index] <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- output stage
   logic [WORD_WIDTH-1:0] r_next;
   logic [WORD_WIDTH-1:0] s_next;
   logic                  s_sel_ok;
   logic                  bypass_r;
   logic                  bypass_s;

   assign s_sel_ok = int'(s_read_index) < S_COUNT;
   assign bypass_r = commit_r && (head_thread == rd_thread);
   assign bypass_s = commit_s && (head_thread == rd_thread) && (commit_s_index == s_read_index);

   always_comb begin
      r_next = '0;
      if (bypass_r) begin
         r_next = head_data;
      end else if (r_written[rd_thread]) begin
         r_next = r_file[rd_thread];
      end
   end

   always_comb begin
      s_next = '0;
      if (bypass_s) begin
         s_next = head_data;
      end else if (s_sel_ok && s_written[rd_thread][s_read_index]) begin
         s_next = s_file[rd_thread][s_read_index];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         R <= '0;
         S <= '0;
      end else begin
         R <= r_next;
         S <= s_next;
      end
   end

`ifdef DATAPATH_RESULT_FEEDBACK_FLAGS_EN
   assign R_zero     = (R == '0);
   assign R_negative = R[WORD_WIDTH-1];
`else
   assign R_zero     = 1'b0;
   assign R_negative = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_result_feedback.sv
// -----------------------------------------------------------------------------
// tb_datapath_result_feedback
//
// Directed bench for datapath_result_feedback with N=8, P=4, S_COUNT=2 and the
// S window at 0x10. Each step drives one issue slot. A per-thread reference
// model is updated as results are driven. The R/S value that the outputs
// must show one cycle later goes into a scoreboard queue, and that queue is
// popped and compared at the following step. Flag expectations follow the
// DATAPATH_RESULT_FEEDBACK_FLAGS_EN macro.
// -----------------------------------------------------------------------------
module tb_datapath_result_feedback;

   localparam int W  = 36;
   localparam int AW = 12;
   localparam int N  = 8;
   localparam int P  = 4;
   localparam int SC = 2;
   localparam int SB = 16;

   logic          clock;
   logic          reset_n;
   logic [W-1:0]  Ra;
   logic [AW-1:0] write_addr_Ra;
   logic          Ra_valid;
   logic [0:0]    s_read_index;
   logic [W-1:0]  R;
   logic [W-1:0]  S;
   logic          R_zero;
   logic          R_negative;
   logic [2:0]    alu_thread;

   datapath_result_feedback #(
      .WORD_WIDTH        (W),
      .WRITE_ADDR_WIDTH  (AW),
      .THREAD_COUNT      (N),
      .THREAD_COUNT_WIDTH(3),
      .ALU_PIPE_DEPTH    (P),
      .S_COUNT           (SC),
      .S_INDEX_WIDTH     (1),
      .S_BASE_ADDR       (SB),
      .S_RAMSTYLE        ("MLAB")
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .Ra           (Ra),
      .write_addr_Ra(write_addr_Ra),
      .Ra_valid     (Ra_valid),
      .s_read_index (s_read_index),
      .R            (R),
      .S            (S),
      .R_zero       (R_zero),
      .R_negative   (R_negative),
      .alu_thread   (alu_thread)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] r;
      logic [W-1:0] s;
      logic [2:0]   thr;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] r_m [N];
   logic [W-1:0] s_m [N][SC];
   int           cur_m;
   int           checks;
   int           errors;
   int           step_no;

   function automatic logic exp_zero(input logic [W-1:0] r);
`ifdef DATAPATH_RESULT_FEEDBACK_FLAGS_EN
      return (r == '0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic exp_neg(input logic [W-1:0] r);
`ifdef DATAPATH_RESULT_FEEDBACK_FLAGS_EN
      return r[W-1];
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int t = 0; t < N; t++) begin
         r_m[t] = '0;
         for (int k = 0; k < SC; k++) begin
            s_m[t][k] = '0;
         end
      end
      sb.delete();
   endtask

   // Compare the outputs against the oldest pending expectation.
   task automatic check_outputs();
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         $display("step %0d: thread %0d R=0x%0h S=0x%0h zero=%0b neg=%0b (want R=0x%0h S=0x%0h)",
                  step_no, alu_thread, R, S, R_zero, R_negative, e.r, e.s);
         chk("alu_thread_out", {33'd0, alu_thread}, {33'd0, e.thr});
         chk("R", R, e.r);
         chk("S", S, e.s);
         chk("R_zero", {35'd0, R_zero}, {35'd0, exp_zero(e.r)});
         chk("R_negative", {35'd0, R_negative}, {35'd0, exp_neg(e.r)});
      end
   endtask

   // One issue slot; called at posedge+1, returns at the next posedge+1.
   task automatic step(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [0:0] si);
      exp_t e;
      int   tr;
      check_outputs();
      chk("alu_thread", {33'd0, alu_thread}, W'((cur_m + P) % N));
      Ra            = d;
      write_addr_Ra = a;
      Ra_valid      = v;
      s_read_index  = si;
      if (v) begin
         r_m[cur_m] = d;
         if (a >= AW'(SB) && a < AW'(SB + SC)) begin
            s_m[cur_m][int'(a) - SB] = d;
         end
      end
      tr    = (cur_m + P + 1) % N;
      e.r   = r_m[tr];
      e.s   = s_m[tr][si];
      e.thr = 3'(tr);
      sb.push_back(e);
      @(posedge clock);
      #1;
      cur_m   = (cur_m + 1) % N;
      step_no++;
   endtask

   task automatic idle(input logic [0:0] si);
      step(1'b0, 12'h000, 36'h0, si);
   endtask

   initial begin
      logic [31:0]  rnd_lo;
      logic [31:0]  rnd_hi;
      logic [1:0]   rnd_sel;
      logic [AW-1:0] rnd_addr;

      checks        = 0;
      errors        = 0;
      step_no       = 0;
      cur_m         = 0;
      reset_n       = 1'b0;
      Ra            = '0;
      write_addr_Ra = '0;
      Ra_valid      = 1'b0;
      s_read_index  = 1'b0;
      clear_model();

      repeat (2) @(posedge clock);
      #1;
      chk("reset_R", R, '0);
      chk("reset_S", S, '0);
      chk("reset_R_negative", {35'd0, R_negative}, 36'd0);
      chk("reset_R_zero", {35'd0, R_zero}, {35'd0, exp_zero('0)});
      chk("reset_alu_thread", {33'd0, alu_thread}, W'(P % N));
      reset_n = 1'b1;

      // Round 0: first writes
      idle(1'b0);                               // cur 0
      step(1'b1, 12'h011, 36'hA, 1'b0);         // cur 1: thread 1 S[1]
      step(1'b1, 12'h020, 36'h5, 1'b0);         // cur 2: plain R write
      step(1'b1, 12'h020, 36'h7, 1'b0);         // cur 3
      step(1'b1, 12'h010, 36'h44, 1'b1);        // cur 4: thread 4 S[0]; read thread 1 S[1]
      idle(1'b1);                               // cur 5: read thread 2 S[1] (unwritten)
      step(1'b1, 12'h020, 36'h800000000, 1'b0); // cur 6: negative result
      idle(1'b0);                               // cur 7: read thread 4 S[0], bypassed

      // Round 1: annul hold, out-of-window address, zero result
      idle(1'b0);                               // cur 0
      idle(1'b0);                               // cur 1
      step(1'b1, 12'h012, 36'h33, 1'b0);        // cur 2: just past the S window
      step(1'b0, 12'h011, 36'h9, 1'b1);         // cur 3: annulled
      idle(1'b0);                               // cur 4: read thread 1 S[0] -> 0
      idle(1'b0);                               // cur 5: thread 2 R=0x33, S[0]=0
      step(1'b1, 12'h020, 36'h0, 1'b1);         // cur 6: zero result; read thread 3
      idle(1'b0);                               // cur 7

      // Round 2: results in flight when reset hits
      idle(1'b1);                               // cur 0
      idle(1'b0);                               // cur 1: thread 6 R=0
      idle(1'b0);                               // cur 2
      step(1'b1, 12'h020, 36'h111, 1'b0);       // cur 3
      step(1'b1, 12'h010, 36'h222, 1'b0);       // cur 4
      step(1'b1, 12'h011, 36'h333, 1'b0);       // cur 5: read thread 2
      check_outputs();

      reset_n = 1'b0;
      #1;
      chk("midreset_R", R, '0);
      chk("midreset_S", S, '0);
      chk("midreset_R_negative", {35'd0, R_negative}, 36'd0);
      chk("midreset_R_zero", {35'd0, R_zero}, {35'd0, exp_zero('0)});
      chk("midreset_alu_thread", {33'd0, alu_thread}, W'(P % N));
      clear_model();
      cur_m = 0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Two rounds after reset: nothing from before may reappear.
      for (int i = 0; i < 2 * N; i++) begin
         idle(1'(i / N));
      end

      // Mixed traffic
      for (int i = 0; i < 32; i++) begin
         rnd_lo  = $urandom;
         rnd_hi  = $urandom;
         rnd_sel = 2'($urandom_range(0, 3));
         case (rnd_sel)
            2'd0:    rnd_addr = 12'h010;
            2'd1:    rnd_addr = 12'h011;
            2'd2:    rnd_addr = 12'h00F;
            default: rnd_addr = 12'h020;
         endcase
         step(1'($urandom_range(0, 3) != 0), rnd_addr, {rnd_hi[3:0], rnd_lo},
              1'($urandom_range(0, 1)));
      end
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/datapath_result_feedback.md
# datapath_result_feedback

Per-thread result feedback for the triadic ALU. It replaces the fixed R delay line and single-entry S register with annul-aware, per-thread R storage and a small per-thread S register file. It sits between the ALU outputs (Ra, write_addr_Ra) and the ALU R/S operand inputs. It delivers each thread's last committed result exactly when that thread next issues to the ALU.

## Interface
Parameters:
- WORD_WIDTH, 36, data width
- WRITE_ADDR_WIDTH, 12, width of write_addr_Ra
- THREAD_COUNT, 8, interleaved threads N; N ≥ ALU_PIPE_DEPTH+2
- THREAD_COUNT_WIDTH, 3, clog2(N)
- ALU_PIPE_DEPTH, 4, ALU latency P
- S_COUNT, 2, S registers per thread
- S_INDEX_WIDTH, 1, clog2(S_COUNT), minimum 1
- S_BASE_ADDR, 0, write address of S[0]; S[k] at S_BASE_ADDR+k
- S_RAMSTYLE, "MLAB", S/R file RAM style

Ports:
- clock  in  1  clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- Ra  in  WORD_WIDTH  ALU result
- write_addr_Ra  in  WRITE_ADDR_WIDTH  result write address
- Ra_valid  in  1  result from a non-annulled, non-cancelled instruction
- s_read_index  in  S_INDEX_WIDTH  S entry for the thread issuing next cycle
- R  out  WORD_WIDTH  previous committed result of the issuing thread
- S  out  WORD_WIDTH  selected S entry of the issuing thread
- R_zero  out  1  R == 0
- R_negative  out  1  R MSB
- alu_thread  out  THREAD_COUNT_WIDTH  thread whose R/S are on outputs

## Operation
- Thread counter cur: increments each cycle and wraps N-1→0. Reset value is 0.
- Each cycle, {Ra_valid, write_addr_Ra, Ra, cur} enters a delay pipeline of depth D = N-P-1. Pipeline valid bits reset to 0.
- Commit stage (pipeline head, thread T):
  - Ra_valid=1: write R_file[T] ← data.
  - Ra_valid=1 and address in [S_BASE_ADDR, S_BASE_ADDR+S_COUNT): also write S_file[T][addr−S_BASE_ADDR].
  - Ra_valid=0: no write; R and S for thread T keep their previous values (annul hold).
  - Addresses outside the S range never touch S.
- Written-flag vectors: R has N bits, S has N×S_COUNT bits. All cleared by reset; each set on its first write. A read of an unwritten entry returns 0. RAM contents themselves are not reset.
- Output stage, registered, one cycle after commit, for thread T = alu_thread:
  - R ← R_file[T].
  - S ← S_file[T][s_read_index sampled in the commit cycle].
  - Same-cycle commit to the same entry is bypassed: new data is output, never stale.
- alu_thread = (cur + P) mod N, combinational.
- Reset mid-operation: in-flight results are discarded (valid bits cleared). R, S, R_zero and R_negative go to 0 asynchronously. R_zero returns 1 only when the macro is defined.

## Timing
- Ra presented at cycle t with cur=T appears on R at cycle t+N−P, which is when alu_thread=T.
- For N=8, P=4: D=3; commit at t+3; R/S valid at t+4.
- s_read_index is sampled one cycle before its S value is output.
- Reset values: R=0, S=0, R_negative=0, alu_thread=P mod N, R_zero=1 (or 0 without the macro).
- Throughput: one result per cycle, no stalls, no backpressure.

## Configuration
- DATAPATH_RESULT_FEEDBACK_FLAGS_EN defined: R_zero and R_negative are decoded combinationally from the R output register.
- Not defined: both flags are tied to 0 and no decode logic exists.

## Test plan
Bench uses N=8, P=4, S_COUNT=2, S_BASE_ADDR=0x10, flags macro defined.
- Reset release, then Ra=0x5 valid, addr 0x20, at cycle t, cur=2 → at t+4, alu_thread=2, R=0x5, R_zero=0. S stays 0, since it has never been written.
- Thread 3 commits 0x7 valid, then next round Ra=0x9 with Ra_valid=0 → thread 3's following issue still shows R=0x7 (annul hold).
- Thread 1 writes 0xA to addr 0x11 → S=0xA when s_read_index=1 for thread 1, and S=0 for index 0. Thread 2 index 1 also reads 0.
- Commit to S_file[4][0] while s_read_index=0 is sampled in the same cycle for thread 4 → S shows the new value (bypass).
- Ra=0x800000000 valid → R_negative=1 at t+4. Then Ra=0 valid → R_zero=1 one round later.
- Assert reset_n low with 3 results in flight → outputs 0 immediately; after release, those results never appear and cur restarts at 0.
